// File: rtl/rr_sel_2to1_pkg.sv
// Shared definitions for the two-requester round-robin mux select controller.
// The state encoding and select polarity are also used by the mux testbenches.
package rr_sel_pkg;

    // FSM state encoding
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SERVE1 = 2'd1;
    localparam logic [1:0] SERVE2 = 2'd2;

    // Mux select polarity: 0 picks D1, 1 picks D2
    localparam logic SEL_D1 = 1'b0;
    localparam logic SEL_D2 = 1'b1;

    // Last-served pointer values
    localparam logic LAST_REQ1 = 1'b0;
    localparam logic LAST_REQ2 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = IDLE,
        ST_SERVE1 = SERVE1,
        ST_SERVE2 = SERVE2
    } state_t;

    // On a tie the requester that was not served last wins
    function automatic state_t tie_winner(logic last_served);
        return (last_served == LAST_REQ2) ? ST_SERVE1 : ST_SERVE2;
    endfunction

    // Select value for a state; IDLE keeps the previous select so the mux does not glitch
    function automatic logic sel_for(state_t st, logic held_sel);
        logic sel;
        sel = held_sel;
        case (st)
            ST_SERVE1: sel = SEL_D1;
            ST_SERVE2: sel = SEL_D2;
            default:   sel = held_sel;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/rr_sel_2to1_if.sv
// Request/grant/data bundle between the requesters, the 2:1 mux and the controller.
// The controller uses the slave view; the requester/mux side uses the master view.
interface rr_sel_2to1_if;

    logic REQ1;
    logic REQ2;
    logic Y_IN;
    logic S;
    logic GNT1;
    logic GNT2;
    logic Q;
    logic Q_VALID;
    logic Q_SRC;

    modport master (
        output REQ1,
        output REQ2,
        output Y_IN,
        input  S,
        input  GNT1,
        input  GNT2,
        input  Q,
        input  Q_VALID,
        input  Q_SRC
    );

    modport slave (
        input  REQ1,
        input  REQ2,
        input  Y_IN,
        output S,
        output GNT1,
        output GNT2,
        output Q,
        output Q_VALID,
        output Q_SRC
    );

endinterface

// File: rtl/rr_sel_2to1_burst_counter.sv
// Beat counter for one grant burst. Clear has priority over enable, the count
// saturates at BURST_LEN, and done flags that the beat counted now completes the burst.
module burst_counter #(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic done
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] SAT_VAL   = CNT_W'(BURST_LEN);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear to zero, otherwise step up until saturated
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en && (count_q != SAT_VAL)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    assign done = (count_q == LAST_BEAT) || (count_q == SAT_VAL);

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rr_sel_2to1.sv
// Round-robin select controller for the 2:1 mux: grants the path to one requester
// at a time in bursts of up to BURST_LEN beats, drives S and registers the mux output.
module rr_sel_2to1 #(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 4
) (
    input  logic         CLK,
    input  logic         RST,
    rr_sel_2to1_if.slave bus
);

    import rr_sel_pkg::*;

    state_t state_q;
    state_t state_d;
    logic   ptr_q;
    logic   ptr_d;
    logic   s_q;
    logic   s_d;
    logic   gnt1_q;
    logic   gnt1_d;
    logic   gnt2_q;
    logic   gnt2_d;
    logic   q_q;
    logic   q_d;
    logic   q_valid_q;
    logic   q_valid_d;
    logic   q_src_q;
    logic   q_src_d;

    logic   cnt_clear;
    logic   cnt_en;
    logic   burst_done;

    burst_counter #(
        .BURST_LEN(BURST_LEN),
        .CNT_W    (CNT_W)
    ) u_burst (
        .clk  (CLK),
        .rst  (RST),
        .clear(cnt_clear),
        .en   (cnt_en),
        .done (burst_done)
    );

    // Grant arbitration: pick the next owner, manage the burst count and last-served pointer
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_clear = 1'b1;
                if (bus.REQ1 && bus.REQ2) begin
                    state_d = tie_winner(ptr_q);
                end else if (bus.REQ1) begin
                    state_d = ST_SERVE1;
                end else if (bus.REQ2) begin
                    state_d = ST_SERVE2;
                end
            end
            ST_SERVE1: begin
                if (!bus.REQ1 || burst_done) begin
                    cnt_clear = 1'b1;
                    if (bus.REQ2) begin
                        state_d = ST_SERVE2;
                        ptr_d   = LAST_REQ1;
                    end else if (bus.REQ1) begin
                        state_d = ST_SERVE1;
                    end else begin
                        state_d = ST_IDLE;
                        ptr_d   = LAST_REQ1;
                    end
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_SERVE2: begin
                if (!bus.REQ2 || burst_done) begin
                    cnt_clear = 1'b1;
                    if (bus.REQ1) begin
                        state_d = ST_SERVE1;
                        ptr_d   = LAST_REQ2;
                    end else if (bus.REQ2) begin
                        state_d = ST_SERVE2;
                    end else begin
                        state_d = ST_IDLE;
                        ptr_d   = LAST_REQ2;
                    end
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cnt_clear = 1'b1;
            end
        endcase
    end

    // Grant and select outputs follow the next state so they come straight out of flops
    always_comb begin
        gnt1_d = (state_d == ST_SERVE1);
        gnt2_d = (state_d == ST_SERVE2);
        s_d    = sel_for(state_d, s_q);
    end

    // Output capture: sample the mux output on every granted beat, hold otherwise
    always_comb begin
        q_d       = q_q;
        q_valid_d = 1'b0;
        q_src_d   = q_src_q;
        if (gnt1_q || gnt2_q) begin
            q_d       = bus.Y_IN;
            q_valid_d = 1'b1;
            q_src_d   = s_q;
        end
    end

    // All controller state and registered outputs, synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            ptr_q     <= LAST_REQ2;
            s_q       <= SEL_D1;
            gnt1_q    <= 1'b0;
            gnt2_q    <= 1'b0;
            q_q       <= 1'b0;
            q_valid_q <= 1'b0;
            q_src_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            s_q       <= s_d;
            gnt1_q    <= gnt1_d;
            gnt2_q    <= gnt2_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            q_src_q   <= q_src_d;
        end
    end

    assign bus.S       = s_q;
    assign bus.GNT1    = gnt1_q;
    assign bus.GNT2    = gnt2_q;
    assign bus.Q       = q_q;
    assign bus.Q_VALID = q_valid_q;
    assign bus.Q_SRC   = q_src_q;

endmodule

// File: tb/tb_rr_sel_2to1.sv
// Testbench for rr_sel_2to1: two instances (burst of 4 and burst of 1) share the
// same requests and mux data and are compared against a cycle-level reference model.
module tb_rr_sel_2to1;

    import rr_sel_pkg::*;

    localparam int BL0 = 4;
    localparam int BL1 = 1;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic d1  = 1'b0;
    logic d2  = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state per instance: owner 0 = nobody, 1 or 2 = requester
    int   owner [2];
    int   beats [2];
    int   last  [2];
    int   bl    [2];
    logic ms    [2];
    logic mq    [2];
    logic mqv   [2];
    logic mqsrc [2];

    rr_sel_2to1_if bus0 ();
    rr_sel_2to1_if bus1 ();

    // Behavioural 2:1 mux in front of each controller
    assign bus0.Y_IN = bus0.S ? d2 : d1;
    assign bus1.Y_IN = bus1.S ? d2 : d1;

    rr_sel_2to1 #(.BURST_LEN(BL0), .CNT_W(4)) u_dut0 (.CLK(CLK), .RST(RST), .bus(bus0));
    rr_sel_2to1 #(.BURST_LEN(BL1), .CNT_W(4)) u_dut1 (.CLK(CLK), .RST(RST), .bus(bus1));

    // Free-running clock
    always #5 CLK = ~CLK;

    // One clock edge of the reference model
    task automatic modelStep(input int k, input bit r1, input bit r2, input bit rst,
                             input bit dv1, input bit dv2);
        bit want [3];
        int x;
        int o;
        if (rst) begin
            owner[k] = 0; beats[k] = 0; last[k] = 2;
            ms[k] = 1'b0; mq[k] = 1'b0; mqv[k] = 1'b0; mqsrc[k] = 1'b0;
            return;
        end
        if (owner[k] != 0) begin
            mq[k]    = ms[k] ? dv2 : dv1;
            mqv[k]   = 1'b1;
            mqsrc[k] = ms[k];
        end else begin
            mqv[k] = 1'b0;
        end
        want[0] = 1'b0; want[1] = r1; want[2] = r2;
        if (owner[k] == 0) begin
            beats[k] = 0;
            if (r1 && r2)  owner[k] = 3 - last[k];
            else if (r1)   owner[k] = 1;
            else if (r2)   owner[k] = 2;
        end else begin
            x = owner[k];
            o = 3 - x;
            if (want[x] && (beats[k] + 1 < bl[k])) begin
                beats[k]++;
            end else begin
                beats[k] = 0;
                if (want[o]) begin
                    owner[k] = o; last[k] = x;
                end else if (!want[x]) begin
                    owner[k] = 0; last[k] = x;
                end
            end
        end
        if (owner[k] == 1)      ms[k] = SEL_D1;
        else if (owner[k] == 2) ms[k] = SEL_D2;
    endtask

    // Drive one cycle of inputs, clock it, advance the model, settle before sampling
    task automatic applyStimulus(input bit r1, input bit r2, input bit rst,
                                 input bit dv1, input bit dv2);
        @(negedge CLK);
        RST = rst;
        bus0.REQ1 = r1; bus0.REQ2 = r2;
        bus1.REQ1 = r1; bus1.REQ2 = r2;
        d1 = dv1; d2 = dv2;
        @(posedge CLK);
        for (int k = 0; k < 2; k++) modelStep(k, r1, r2, rst, dv1, dv2);
        cyc++;
        #1;
    endtask

    function automatic logic [5:0] expVec(input int k);
        return {owner[k] == 1, owner[k] == 2, ms[k], mq[k], mqv[k], mqsrc[k]};
    endfunction

    function automatic logic [5:0] obsVec(input int k);
        if (k == 0)
            return {bus0.GNT1, bus0.GNT2, bus0.S, bus0.Q, bus0.Q_VALID, bus0.Q_SRC};
        return {bus1.GNT1, bus1.GNT2, bus1.S, bus1.Q, bus1.Q_VALID, bus1.Q_SRC};
    endfunction

    task automatic test_reset();
        applyStimulus(1, 1, 1, 1, 1);
        applyStimulus(1, 1, 1, 1, 0);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obsVec(k) !== 6'b0) begin
                bad++;
                $display("[TB] FAIL reset_values inst=%0d got=%b want=%b", k, obsVec(k), 6'b0);
            end
        end
        applyStimulus(1, 1, 0, 1'($urandom), 1'($urandom));
        total++;
        if ({bus0.GNT1, bus0.GNT2, bus0.S} !== 3'b100) begin
            bad++;
            $display("[TB] FAIL first_grant got=%b want=100", {bus0.GNT1, bus0.GNT2, bus0.S});
        end
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obsVec(k) !== expVec(k)) begin
                bad++;
                $display("[TB] FAIL reset_model inst=%0d cyc=%0d got=%b want=%b", k, cyc, obsVec(k), expVec(k));
            end
        end
    endtask

    task automatic test_alternate();
        bit want1;
        bit want1b;
        applyStimulus(1, 1, 1, 0, 0);
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1, 1, 0, 1'($urandom), 1'($urandom));
            want1  = (((i - 1) / BL0) % 2) == 0;
            want1b = ((i - 1) % 2) == 0;
            total++;
            if ({bus0.GNT1, bus0.GNT2} !== {want1, !want1}) begin
                bad++;
                $display("[TB] FAIL alternate_burst4 i=%0d got=%b want=%b", i, {bus0.GNT1, bus0.GNT2}, {want1, !want1});
            end
            total++;
            if ({bus1.GNT1, bus1.GNT2} !== {want1b, !want1b}) begin
                bad++;
                $display("[TB] FAIL alternate_burst1 i=%0d got=%b want=%b", i, {bus1.GNT1, bus1.GNT2}, {want1b, !want1b});
            end
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obsVec(k) !== expVec(k)) begin
                    bad++;
                    $display("[TB] FAIL alternate_model inst=%0d cyc=%0d got=%b want=%b", k, cyc, obsVec(k), expVec(k));
                end
            end
        end
    endtask

    task automatic test_req1_only();
        applyStimulus(0, 0, 1, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1, 0, 0, 1'($urandom), 1'($urandom));
            total++;
            if ({bus0.GNT1, bus0.GNT2, bus0.S, bus1.GNT1, bus1.GNT2, bus1.S} !== 6'b100100) begin
                bad++;
                $display("[TB] FAIL req1_hold i=%0d got=%b want=100100", i,
                         {bus0.GNT1, bus0.GNT2, bus0.S, bus1.GNT1, bus1.GNT2, bus1.S});
            end
        end
        applyStimulus(0, 0, 0, 0, 0);
        total++;
        if ({bus0.GNT1, bus0.GNT2, bus0.S} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL req1_idle got=%b want=000", {bus0.GNT1, bus0.GNT2, bus0.S});
        end
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obsVec(k) !== expVec(k)) begin
                bad++;
                $display("[TB] FAIL req1_model inst=%0d cyc=%0d got=%b want=%b", k, cyc, obsVec(k), expVec(k));
            end
        end
    endtask

    task automatic test_q_follow();
        applyStimulus(0, 0, 1, 0, 1);
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(1, 1, 0, 0, 1);
            if (i > 1) begin
                total++;
                if ({bus0.Q_VALID, bus0.Q} !== {1'b1, bus0.Q_SRC}) begin
                    bad++;
                    $display("[TB] FAIL q_tracks_src i=%0d got_qv_q=%b src=%b", i, {bus0.Q_VALID, bus0.Q}, bus0.Q_SRC);
                end
            end
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obsVec(k) !== expVec(k)) begin
                    bad++;
                    $display("[TB] FAIL q_model inst=%0d cyc=%0d got=%b want=%b", k, cyc, obsVec(k), expVec(k));
                end
            end
        end
    endtask

    task automatic test_rst_mid();
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 1, 0, 1, 1);
        applyStimulus(0, 1, 0, 1, 1);
        total++;
        if ({bus0.GNT2, bus0.S, bus0.Q_VALID} !== 3'b111) begin
            bad++;
            $display("[TB] FAIL rst_mid_setup got=%b want=111", {bus0.GNT2, bus0.S, bus0.Q_VALID});
        end
        applyStimulus(1, 1, 1, 1, 1);
        total++;
        if ({bus0.GNT1, bus0.GNT2, bus0.S, bus0.Q, bus0.Q_VALID, bus0.Q_SRC} !== 6'b0) begin
            bad++;
            $display("[TB] FAIL rst_mid_clear got=%b want=000000", obsVec(0));
        end
        applyStimulus(1, 1, 0, 0, 1);
        total++;
        if ({bus0.GNT1, bus0.GNT2, bus0.S} !== 3'b100) begin
            bad++;
            $display("[TB] FAIL rst_mid_ptr got=%b want=100", {bus0.GNT1, bus0.GNT2, bus0.S});
        end
    endtask

    task automatic test_switch();
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 1);
        total++;
        if ({bus0.GNT1, bus0.GNT2, bus0.S} !== 3'b100) begin
            bad++;
            $display("[TB] FAIL direct_switch got=%b want=100", {bus0.GNT1, bus0.GNT2, bus0.S});
        end
        applyStimulus(1, 0, 0, 0, 1);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obsVec(k) !== expVec(k)) begin
                bad++;
                $display("[TB] FAIL switch_model inst=%0d cyc=%0d got=%b want=%b", k, cyc, obsVec(k), expVec(k));
            end
        end
    endtask

    task automatic test_random();
        bit r1;
        bit r2;
        bit rs;
        applyStimulus(0, 0, 1, 0, 0);
        for (int i = 0; i < 400; i++) begin
            r1 = 1'($urandom);
            r2 = 1'($urandom);
            rs = ($urandom_range(0, 49) == 0);
            applyStimulus(r1, r2, rs, 1'($urandom), 1'($urandom));
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obsVec(k) !== expVec(k)) begin
                    bad++;
                    $display("[TB] FAIL random_model inst=%0d cyc=%0d got=%b want=%b", k, cyc, obsVec(k), expVec(k));
                end
            end
        end
    endtask

    // Test sequence
    initial begin
        bl[0] = BL0;
        bl[1] = BL1;
        for (int k = 0; k < 2; k++) modelStep(k, 0, 0, 1, 0, 0);
        bus0.REQ1 = 1'b0; bus0.REQ2 = 1'b0;
        bus1.REQ1 = 1'b0; bus1.REQ2 = 1'b0;
        $display("[TB] starting");
        test_reset();
        test_alternate();
        test_req1_only();
        test_q_follow();
        test_rst_mid();
        test_switch();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
